// File: rtl/fpu_pkg.sv
// Shared floating-point register file constants: geometry and write half-select encoding.
// The helper builds the register-indexed one-hot mask that the scoreboard uses.
package fpu_pkg;

  localparam int FPR_DEPTH = 16;
  localparam int FPR_AW    = 4;
  localparam int FPR_DW    = 64;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_LO   = 2'b01;
  localparam logic [1:0] WR_HI   = 2'b10;
  localparam logic [1:0] WR_FULL = 2'b11;

  function automatic logic [FPR_DEPTH-1:0] fpr_onehot(input logic [FPR_AW-1:0] fd);
    logic [FPR_DEPTH-1:0] mask;
    mask     = '0;
    mask[fd] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/fpr_wb_arbiter_if.sv
// Bus between the FP write-back requesters / issue stage (master) and the write-back arbiter (slave).
interface fpr_wb_arbiter_if
  import fpu_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 64
);

  logic [N-1:0]           req_valid;
  logic [4*N-1:0]         req_fd;
  logic [2*N-1:0]         req_wr;
  logic [DW*N-1:0]        req_data;
  logic [N-1:0]           req_ready;

  logic                   issue_valid;
  logic [FPR_AW-1:0]      issue_fd;
  logic                   issue_ok;
  logic [FPR_DEPTH-1:0]   pending;

  logic [1:0]             fpr_wr;
  logic [FPR_AW-1:0]      fpr_fd;
  logic [DW-1:0]          fpr_din;

  modport master (
    output req_valid, req_fd, req_wr, req_data, issue_valid, issue_fd,
    input  req_ready, issue_ok, pending, fpr_wr, fpr_fd, fpr_din
  );

  modport slave (
    input  req_valid, req_fd, req_wr, req_data, issue_valid, issue_fd,
    output req_ready, issue_ok, pending, fpr_wr, fpr_fd, fpr_din
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the grant goes to the first valid requester at or after ptr;
// ptr then moves to one past the winner.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  valid,
  output logic [N-1:0]  grant,
  output logic [GW-1:0] grant_idx
);

  logic [GW-1:0] ptr;
  logic          found;

  // NOTE: combinational blocks use blocking '=' and give every output a default
  // first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!found && valid[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = GW'(idx);
      end
    end
  end

  // NOTE: clocked state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (grant_idx == GW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fpr_wb_arbiter.sv
// FP register-file write-back arbiter: round-robin grant, registered write command,
// and a 16-entry scoreboard of destination registers with outstanding writes.
module fpr_wb_arbiter
  import fpu_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 64
) (
  input logic             clk,
  input logic             rst,
  fpr_wb_arbiter_if.slave bus
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]         grant;
  logic [GW-1:0]        grant_idx;
  logic                 any_grant;

  logic                 commit_v;
  logic [1:0]           wr_q;
  logic [FPR_AW-1:0]    fd_q;
  logic [DW-1:0]        din_q;
  logic [FPR_DEPTH-1:0] pending_q;
  logic [FPR_DEPTH-1:0] pending_next;

  rr_arbiter #(.N(N), .GW(GW)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .valid     (bus.req_valid),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign any_grant     = |grant;
  assign bus.req_ready = grant;
  assign bus.issue_ok  = ~pending_q[bus.issue_fd];
  assign bus.pending   = pending_q;
  assign bus.fpr_wr    = wr_q;
  assign bus.fpr_fd    = fd_q;
  assign bus.fpr_din   = din_q;

  // Idle cycles drop the write enable but keep address/data, so the file sees no toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_v <= 1'b0;
      wr_q     <= WR_NONE;
      fd_q     <= '0;
      din_q    <= '0;
    end else if (any_grant) begin
      commit_v <= 1'b1;
      wr_q     <= bus.req_wr[int'(grant_idx)*2 +: 2];
      fd_q     <= bus.req_fd[int'(grant_idx)*FPR_AW +: FPR_AW];
      din_q    <= bus.req_data[int'(grant_idx)*DW +: DW];
    end else begin
      commit_v <= 1'b0;
      wr_q     <= WR_NONE;
    end
  end

  // Clear is applied before set so a same-edge claim of the retiring register wins.
  always_comb begin
    pending_next = pending_q;
    if (commit_v) begin
      pending_next = pending_next & ~fpr_onehot(fd_q);
    end
    if (bus.issue_valid && bus.issue_ok) begin
      pending_next = pending_next | fpr_onehot(bus.issue_fd);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_next;
    end
  end

endmodule

// File: tb/tb_fpr_wb_arbiter.sv
// Self-checking bench for fpr_wb_arbiter: table-driven grant sequence, directed corner
// sequences, and randomized traffic compared against a transaction-level model.
module tb_fpr_wb_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;

  logic clk;
  logic rst;

  fpr_wb_arbiter_if #(.N(N), .DW(DW)) bus ();

  fpr_wb_arbiter #(.N(N), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state: priority pointer, per-register pending flags, output command.
  int         m_ptr;
  bit         m_pend[16];
  logic [1:0] m_wr;
  logic [3:0] m_fd;
  logic [63:0] m_din;
  bit         m_commit;
  int         last_g;

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] exp_ready;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    foreach (m_pend[r]) m_pend[r] = 1'b0;
    m_wr     = 2'b00;
    m_fd     = 4'd0;
    m_din    = 64'd0;
    m_commit = 1'b0;
    last_g   = -1;
  endtask

  task automatic clear_inputs();
    bus.req_valid   = '0;
    bus.req_fd      = '0;
    bus.req_wr      = '0;
    bus.req_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_fd    = 4'd0;
  endtask

  task automatic drive_req(input int i, input logic v, input logic [3:0] fd,
                           input logic [1:0] wr, input logic [63:0] d);
    bus.req_valid[i]        = v;
    bus.req_fd[4*i +: 4]    = fd;
    bus.req_wr[2*i +: 2]    = wr;
    bus.req_data[64*i +: 64] = d;
  endtask

  task automatic drive_issue(input logic v, input logic [3:0] fd);
    bus.issue_valid = v;
    bus.issue_fd    = fd;
  endtask

  // Called just after a rising edge with this cycle's inputs already driven: compares
  // every output against the model, advances the model across the edge, waits for it.
  task automatic tick();
    int         g;
    logic [N-1:0] er;
    logic [15:0] pv;
    bit         ok;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (g < 0 && bus.req_valid[idx]) g = idx;
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    for (int r = 0; r < 16; r++) pv[r] = m_pend[r];
    ok = !m_pend[bus.issue_fd];
    check("req_ready", 64'(bus.req_ready), 64'(er));
    check("issue_ok",  64'(bus.issue_ok),  64'(ok));
    check("pending",   64'(bus.pending),   64'(pv));
    check("fpr_wr",    64'(bus.fpr_wr),    64'(m_wr));
    check("fpr_fd",    64'(bus.fpr_fd),    64'(m_fd));
    check("fpr_din",   bus.fpr_din,        m_din);
    if (m_commit) m_pend[m_fd] = 1'b0;
    if (bus.issue_valid && ok) m_pend[bus.issue_fd] = 1'b1;
    if (g >= 0) begin
      m_wr     = bus.req_wr[2*g +: 2];
      m_fd     = bus.req_fd[4*g +: 4];
      m_din    = bus.req_data[64*g +: 64];
      m_commit = 1'b1;
      m_ptr    = (g + 1) % N;
    end else begin
      m_wr     = 2'b00;
      m_commit = 1'b0;
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  bit         s_v[N];
  logic [3:0] s_fd[N];
  logic [1:0] s_wr[N];
  logic [63:0] s_d[N];

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();

    // Reset state
    do_reset();
    check("reset_fpr_wr",  64'(bus.fpr_wr),  64'd0);
    check("reset_pending", 64'(bus.pending), 64'd0);
    tick();

    // Table-driven grant sequence from ptr = 0
    tbl[0]  = '{4'b0010, 4'b0010};
    tbl[1]  = '{4'b1111, 4'b0100};
    tbl[2]  = '{4'b1111, 4'b1000};
    tbl[3]  = '{4'b1111, 4'b0001};
    tbl[4]  = '{4'b1111, 4'b0010};
    tbl[5]  = '{4'b0000, 4'b0000};
    tbl[6]  = '{4'b0011, 4'b0001};
    tbl[7]  = '{4'b0011, 4'b0010};
    tbl[8]  = '{4'b1001, 4'b1000};
    tbl[9]  = '{4'b1001, 4'b0001};
    tbl[10] = '{4'b0001, 4'b0001};
    tbl[11] = '{4'b1100, 4'b0100};
    do_reset();
    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < N; i++)
        drive_req(i, tbl[v].valid[i], 4'(4 + i), 2'b11, 64'hA0 + 64'(i));
      #1;
      check("tbl_ready", 64'(bus.req_ready), 64'(tbl[v].exp_ready));
      tick();
    end
    clear_inputs();
    tick();

    // Single request
    do_reset();
    drive_req(1, 1'b1, 4'd5, 2'b11, 64'h3FF0000000000000);
    #1;
    check("single_ready", 64'(bus.req_ready), 64'b0010);
    tick();
    clear_inputs();
    check("single_wr",  64'(bus.fpr_wr), 64'b11);
    check("single_fd",  64'(bus.fpr_fd), 64'd5);
    check("single_din", bus.fpr_din, 64'h3FF0000000000000);
    tick();
    check("single_once", 64'(bus.fpr_wr), 64'b00);
    tick();

    // Fairness: all four valid for 8 cycles
    do_reset();
    for (int i = 0; i < N; i++) drive_req(i, 1'b1, 4'(4 + i), 2'b11, 64'(i));
    for (int c = 0; c < 8; c++) begin
      #1;
      check("fair_ready", 64'(bus.req_ready), 64'(1) << (c % 4));
      if (c > 0) check("fair_fd", 64'(bus.fpr_fd), 64'(4 + ((c - 1) % 4)));
      tick();
    end
    clear_inputs();
    tick();

    // Scoreboard: issue fd 7, blocked re-issue, then write-back by requester 2
    do_reset();
    drive_issue(1'b1, 4'd7);
    tick();
    drive_issue(1'b0, 4'd0);
    check("sb_set", 64'(bus.pending[7]), 64'd1);
    drive_issue(1'b1, 4'd7);
    #1;
    check("sb_block_ok", 64'(bus.issue_ok), 64'd0);
    tick();
    drive_issue(1'b0, 4'd0);
    check("sb_block_state", 64'(bus.pending), 64'h0080);
    drive_req(2, 1'b1, 4'd7, 2'b10, 64'hDEAD_BEEF_0000_0007);
    tick();
    clear_inputs();
    check("sb_k1_pend", 64'(bus.pending[7]), 64'd1);
    check("sb_k1_wr",   64'(bus.fpr_wr), 64'b10);
    check("sb_k1_fd",   64'(bus.fpr_fd), 64'd7);
    tick();
    check("sb_k2_pend", 64'(bus.pending[7]), 64'd0);

    // Set/clear collision on fd 3
    drive_req(0, 1'b1, 4'd3, 2'b11, 64'h33);
    tick();
    clear_inputs();
    drive_issue(1'b1, 4'd3);
    tick();
    drive_issue(1'b0, 4'd0);
    check("collide_set_wins", 64'(bus.pending[3]), 64'd1);

    // No-write request retires pending fd 9
    drive_issue(1'b1, 4'd9);
    tick();
    drive_issue(1'b0, 4'd0);
    drive_req(1, 1'b1, 4'd9, 2'b00, 64'h99);
    tick();
    clear_inputs();
    check("nowr_wr",   64'(bus.fpr_wr), 64'b00);
    check("nowr_k1",   64'(bus.pending[9]), 64'd1);
    tick();
    check("nowr_k2",   64'(bus.pending[9]), 64'd0);

    // Asynchronous reset mid-operation
    do_reset();
    for (int r = 4; r < 8; r++) begin
      drive_issue(1'b1, 4'(r));
      tick();
    end
    drive_issue(1'b0, 4'd0);
    drive_req(3, 1'b1, 4'd1, 2'b11, 64'h11);
    tick();
    clear_inputs();
    check("pre_rst_wr",  64'(bus.fpr_wr),  64'b11);
    check("pre_rst_pnd", 64'(bus.pending), 64'h00F0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_wr",      64'(bus.fpr_wr),  64'b00);
    check("rst_pending", 64'(bus.pending), 64'h0000);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) drive_req(i, 1'b1, 4'(i), 2'b11, 64'(i));
    #1;
    check("rst_first_grant", 64'(bus.req_ready), 64'b0001);
    tick();
    clear_inputs();
    tick();

    // Randomized traffic with requesters holding until granted
    do_reset();
    foreach (s_v[i]) s_v[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!s_v[i] && ($urandom_range(1, 0) == 1)) begin
          s_v[i]  = 1'b1;
          s_fd[i] = 4'($urandom_range(15, 0));
          s_wr[i] = 2'($urandom_range(3, 0));
          s_d[i]  = {$urandom, $urandom};
        end
        drive_req(i, s_v[i], s_fd[i], s_wr[i], s_d[i]);
      end
      drive_issue(1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)));
      tick();
      if (last_g >= 0) s_v[last_g] = 1'b0;
    end
    clear_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
